codeword_serializer: RTL and testbench

//  Downstream of the LDPC encoder top. Takes each parallel N-bit codeword over a valid/ready

---
 rtl/codeword_serializer_pkg.sv | 13 +
 rtl/codeword_serializer.sv | 106 ++++++++++
 tb/tb_codeword_serializer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/codeword_serializer_pkg.sv
// Shared LDPC codeword parameters and the serializer FSM state type.
// Consumed by the encoder and serializer so both agree on N/K.
package codeword_serializer_pkg;

    localparam int CW_N = 11;  // codeword length
    localparam int CW_K = 6;   // info length, kept alongside N for the encoder

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/codeword_serializer.sv
// Parallel-to-serial codeword serializer, MSB first, with one holding register
// so the next codeword can be handed over while the current one shifts out.
module codeword_serializer
    import codeword_serializer_pkg::*;
#(
    parameter int N = CW_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [N-1:0] codeword,
    input  logic         i_valid,
    output logic         o_ready,
    output logic         o_bit,
    output logic         o_bit_valid,
    input  logic         i_bit_ready,
    output logic         o_sof,
    output logic         o_eof
);

    localparam int               CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    state_e           r_state, w_state_nxt;
    logic [N-1:0]     r_shift, w_shift_nxt;
    logic [N-1:0]     r_hold, w_hold_nxt;
    logic             r_hold_full, w_hold_full_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic w_accept;
    logic w_xfer;
    logic w_last;

    assign o_ready     = i_en & ~r_hold_full;
    assign o_bit_valid = (r_state == ST_SHIFT);
    assign o_bit       = o_bit_valid & r_shift[N-1];
    assign o_sof       = o_bit_valid & (r_cnt == '0);
    assign o_eof       = o_bit_valid & w_last;

    // A disabled block must not consume a bit even if downstream is ready.
    assign w_accept = i_valid & o_ready;
    assign w_xfer   = i_en & o_bit_valid & i_bit_ready;
    assign w_last   = (r_cnt == LAST);

    always_comb begin
        // NOTE: every next-state signal defaults to its register first, so no path infers a latch.
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = codeword;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_xfer && w_last) begin
                    // o_ready is low while the hold is full, so accept cannot coincide with a held frame.
                    if (r_hold_full) begin
                        w_shift_nxt     = r_hold;
                        w_hold_full_nxt = 1'b0;
                        w_cnt_nxt       = '0;
                    end else if (w_accept) begin
                        w_shift_nxt = codeword;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_shift_nxt = {r_shift[N-2:0], 1'b0};
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        w_hold_nxt      = codeword;
                        w_hold_full_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_codeword_serializer.sv
// Self-checking bench: frame-queue reference model of the serial stream,
// directed scenarios followed by a randomized handshake phase.
module tb_codeword_serializer;
    import codeword_serializer_pkg::*;

    localparam int N = CW_N;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_en;
    logic [N-1:0] codeword;
    logic         i_valid;
    logic         o_ready;
    logic         o_bit;
    logic         o_bit_valid;
    logic         i_bit_ready;
    logic         o_sof;
    logic         o_eof;

    codeword_serializer #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .codeword    (codeword),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid),
        .i_bit_ready (i_bit_ready),
        .o_sof       (o_sof),
        .o_eof       (o_eof)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: frames accepted but not fully sent; pos is the bit index within frames[0].
    logic [N-1:0] frames[$];
    int           pos = 0;
    logic [N-1:0] got = '0;
    int           xfers = 0;
    logic [N-1:0] cw_a, cw_b;
    logic         frozen_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs at negedge, then advance the model at posedge.
    task automatic step();
        logic         exp_valid, acc, xf;
        logic [N-1:0] cur;
        @(negedge clk);
        exp_valid = (frames.size() > 0);
        check("o_ready", o_ready, (i_en && frames.size() < 2));
        check("o_bit_valid", o_bit_valid, exp_valid);
        if (exp_valid) begin
            cur = frames[0];
            check("o_bit", o_bit, cur[N-1-pos]);
            check("o_sof", o_sof, (pos == 0));
            check("o_eof", o_eof, (pos == N - 1));
        end
        acc = i_valid && i_en && (frames.size() < 2);
        xf  = exp_valid && i_en && i_bit_ready;
        if (o_bit_valid && i_bit_ready && i_en) begin
            got = {got[N-2:0], o_bit};
            xfers++;
        end
        @(posedge clk);
        if (xf) begin
            if (pos == N - 1) begin
                void'(frames.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
        if (acc) frames.push_back(codeword);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_en = 1'b1; i_valid = 1'b0; i_bit_ready = 1'b1; codeword = '0;
        #2;
        check("rst_bit", o_bit, 1'b0);
        check("rst_valid", o_bit_valid, 1'b0);
        check("rst_sof", o_sof, 1'b0);
        check("rst_eof", o_eof, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Single frame, full-rate downstream.
        xfers = 0;
        codeword = 11'b10110010110; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (12) step();
        check("single_bits", got, 11'b10110010110);
        check("single_xfers", xfers, 11);

        // Back-to-back frames: second one sits in the hold register.
        xfers = 0;
        codeword = 11'h7FF; i_valid = 1'b1;
        step();
        codeword = 11'h000;
        step();
        i_valid = 1'b0;
        repeat (22) step();
        check("b2b_xfers", xfers, 22);
        check("b2b_idle", o_bit_valid, 1'b0);

        // Backpressure: ready toggles every cycle.
        xfers = 0;
        codeword = 11'b01010101010; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            i_bit_ready = i[0];
            step();
        end
        i_bit_ready = 1'b1;
        check("bp_bits", got, 11'b01010101010);
        check("bp_xfers", xfers, 11);

        // Enable low for 5 cycles mid-frame.
        cw_a = N'($urandom);
        codeword = cw_a; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (4) step();
        frozen_bit = o_bit;
        i_en = 1'b0;
        repeat (5) step();
        check("en_frozen_bit", o_bit, frozen_bit);
        i_en = 1'b1;
        repeat (10) step();
        check("en_bits", got, cw_a);

        // Last-bit bypass: offer a new frame exactly on the eof transfer.
        cw_a = N'($urandom);
        cw_b = N'($urandom);
        codeword = cw_a; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (10) step();
        check("bypass_eof", o_eof, 1'b1);
        codeword = cw_b; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("bypass_sof", o_sof, 1'b1);
        check("bypass_ready", o_ready, 1'b1);
        repeat (12) step();
        check("bypass_bits", got, cw_b);

        // Reset in the middle of a frame with a frame also held.
        codeword = N'($urandom); i_valid = 1'b1;
        step();
        codeword = N'($urandom);
        step();
        i_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("midrst_valid", o_bit_valid, 1'b0);
        check("midrst_bit", o_bit, 1'b0);
        check("midrst_sof", o_sof, 1'b0);
        check("midrst_eof", o_eof, 1'b0);
        frames.delete();
        pos = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) step();

        // Randomized handshake traffic.
        for (int i = 0; i < 800; i++) begin
            i_en        = ($urandom_range(0, 9) != 0);
            i_valid     = ($urandom_range(0, 2) != 0);
            i_bit_ready = ($urandom_range(0, 3) != 0);
            codeword    = N'($urandom);
            step();
        end
        i_en = 1'b1; i_valid = 1'b0; i_bit_ready = 1'b1;
        repeat (30) step();
        check("drain_idle", o_bit_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
